// File: rtl/layer_wr_pkg.sv
// Shared canvas defaults, colour constant and scheduler state encoding for the layer write scheduler.
package layer_wr_pkg;

  localparam int DEF_CANVAS_W = 160;
  localparam int DEF_CANVAS_H = 120;
  localparam int DEF_AW       = 15;

  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PT1,
    ST_PT2,
    ST_DRAW,
    ST_CLEAR
  } sched_state_e;

  function automatic logic [1:0] led_code(input sched_state_e s);
    case (s)
      ST_PT1:  return 2'b01;
      ST_PT2:  return 2'b10;
      ST_DRAW: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rect_walker.sv
// Bounding-box raster walker: normalises two corners, steps x inner / y outer, flags pixels to write.
// RECT_FILL_EN defined: every pixel in the box is written; otherwise only the border.
module rect_walker
  import layer_wr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] ax,
  input  logic [6:0] ay,
  input  logic [7:0] bx,
  input  logic [6:0] by,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       pix_wr,
  output logic       done
);

  logic [7:0] xmin, xmax;
  logic [6:0] ymin, ymax;

  always_ff @(posedge clk) begin
    if (reset) begin
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
      x    <= '0;
      y    <= '0;
    end else if (start) begin
      xmin <= (ax < bx) ? ax : bx;
      xmax <= (ax < bx) ? bx : ax;
      ymin <= (ay < by) ? ay : by;
      ymax <= (ay < by) ? by : ay;
      x    <= (ax < bx) ? ax : bx;
      y    <= (ay < by) ? ay : by;
    end else if (step) begin
      if (x == xmax) begin
        x <= xmin;
        y <= y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  assign done = (x == xmax) && (y == ymax);

`ifdef RECT_FILL_EN
  assign pix_wr = 1'b1;
`else
  assign pix_wr = (x == xmin) || (x == xmax) || (y == ymin) || (y == ymax);
`endif

endmodule

// File: rtl/layer_wr_sched.sv
// Arbitrates layer-memory writes: CLEAR sweep > rectangle DRAW > brush pixel; writes hold while wr_ready=0.
// Comb outputs from registered state, one write per accepted cycle; RECT_FILL_EN selects filled rectangles.
module layer_wr_sched
  import layer_wr_pkg::*;
#(
  parameter int CANVAS_W = DEF_CANVAS_W,
  parameter int CANVAS_H = DEF_CANVAS_H,
  parameter int AW       = DEF_AW
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic [7:0]    cursor_x,
  input  logic [6:0]    cursor_y,
  input  logic          record_rect_pt,
  input  logic          draw_rectangle,
  input  logic [2:0]    color,
  input  logic          eraser,
  input  logic [2:0]    layer_en,
  input  logic          brush_req,
  input  logic [7:0]    brush_x,
  input  logic [6:0]    brush_y,
  output logic          brush_ack,
  output logic          wr_en,
  output logic [2:0]    wr_layer,
  output logic [AW-1:0] wr_addr,
  output logic [2:0]    wr_data,
  input  logic          wr_ready,
  output logic [1:0]    rect_state_led,
  output logic          busy
);

  localparam int NPIX = CANVAS_W * CANVAS_H;

  sched_state_e state_q, state_d;

  logic          rrp_q, dr_q;
  logic          rrp_rise, rrp_fall, dr_rise;
  logic [7:0]    p1x, p2x;
  logic [6:0]    p1y, p2y;
  logic [2:0]    col_q, lay_q;
  logic          ers_q;
  logic [AW-1:0] clr_cnt;
  logic          clr_last;
  logic [7:0]    walk_x;
  logic [6:0]    walk_y;
  logic          walk_pix, walk_done, walk_start, walk_step, draw_wr;
  logic          brush_bad;

  assign rrp_rise   = record_rect_pt & ~rrp_q;
  assign rrp_fall   = ~record_rect_pt & rrp_q;
  assign dr_rise    = draw_rectangle & ~dr_q;
  assign clr_last   = (clr_cnt == AW'(NPIX - 1));
  assign draw_wr    = walk_pix && (lay_q != 3'b000);
  assign walk_start = (state_q == ST_PT2) && dr_rise;
  // Interior (or masked-off) positions never wait on the memory.
  assign walk_step  = (state_q == ST_DRAW) && (!draw_wr || wr_ready);
  assign brush_bad  = (layer_en == 3'b000) || (int'(brush_x) >= CANVAS_W) ||
                      (int'(brush_y) >= CANVAS_H);

  rect_walker u_walker (
    .clk    (clk_100MHz),
    .reset  (reset),
    .start  (walk_start),
    .step   (walk_step),
    .ax     (p1x),
    .ay     (p1y),
    .bx     (p2x),
    .by     (p2y),
    .x      (walk_x),
    .y      (walk_y),
    .pix_wr (walk_pix),
    .done   (walk_done)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rrp_q   <= 1'b0;
      dr_q    <= 1'b0;
      p1x     <= '0;
      p1y     <= '0;
      p2x     <= '0;
      p2y     <= '0;
      col_q   <= '0;
      lay_q   <= '0;
      ers_q   <= 1'b0;
      clr_cnt <= '0;
    end else begin
      rrp_q <= record_rect_pt;
      dr_q  <= draw_rectangle;
      if (state_q == ST_IDLE && rrp_rise) begin
        p1x <= cursor_x;
        p1y <= cursor_y;
      end
      if (state_q == ST_PT1 && rrp_fall) begin
        p2x <= cursor_x;
        p2y <= cursor_y;
      end
      if (walk_start) begin
        col_q <= color;
        lay_q <= layer_en;
        ers_q <= eraser;
      end
      if (state_q == ST_CLEAR && wr_ready)
        clr_cnt <= clr_last ? '0 : clr_cnt + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rrp_rise) state_d = ST_PT1;
      ST_PT1:   if (rrp_fall) state_d = ST_PT2;
      ST_PT2:   if (dr_rise) state_d = ST_DRAW;
      ST_DRAW:  if (walk_step && walk_done) state_d = ST_IDLE;
      ST_CLEAR: if (wr_ready && clr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en          = 1'b0;
    wr_layer       = 3'b000;
    wr_addr        = '0;
    wr_data        = 3'b000;
    brush_ack      = 1'b0;
    busy           = !reset && (state_q == ST_CLEAR || state_q == ST_DRAW);
    rect_state_led = reset ? 2'b00 : led_code(state_q);
    if (!reset) begin
      case (state_q)
        ST_CLEAR: begin
          wr_en    = 1'b1;
          wr_layer = 3'b111;
          wr_data  = WHITE;
          wr_addr  = clr_cnt;
        end
        ST_DRAW: begin
          wr_en    = draw_wr;
          wr_layer = lay_q;
          wr_data  = ers_q ? WHITE : col_q;
          wr_addr  = AW'(int'(walk_y) * CANVAS_W + int'(walk_x));
        end
        default: begin
          if (brush_req) begin
            if (brush_bad) begin
              brush_ack = 1'b1;
            end else begin
              wr_en     = 1'b1;
              wr_layer  = layer_en;
              wr_data   = eraser ? WHITE : color;
              wr_addr   = AW'(int'(brush_y) * CANVAS_W + int'(brush_x));
              brush_ack = wr_ready;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_wr_sched.sv
// Randomised bench for layer_wr_sched against a queue-based model of the expected write stream.
module tb_layer_wr_sched;

  localparam int CW   = 160;
  localparam int CH   = 120;
  localparam int NPIX = CW * CH;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cursor_x = '0;
  logic [6:0]  cursor_y = '0;
  logic        record_rect_pt = 1'b0;
  logic        draw_rectangle = 1'b0;
  logic [2:0]  color = '0;
  logic        eraser = 1'b0;
  logic [2:0]  layer_en = '0;
  logic        brush_req = 1'b0;
  logic [7:0]  brush_x = '0;
  logic [6:0]  brush_y = '0;
  logic        brush_ack;
  logic        wr_en;
  logic [2:0]  wr_layer;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ready = 1'b1;
  logic [1:0]  rect_state_led;
  logic        busy;

  layer_wr_sched dut (
    .clk_100MHz     (clk_100MHz),
    .reset          (reset),
    .cursor_x       (cursor_x),
    .cursor_y       (cursor_y),
    .record_rect_pt (record_rect_pt),
    .draw_rectangle (draw_rectangle),
    .color          (color),
    .eraser         (eraser),
    .layer_en       (layer_en),
    .brush_req      (brush_req),
    .brush_x        (brush_x),
    .brush_y        (brush_y),
    .brush_ack      (brush_ack),
    .wr_en          (wr_en),
    .wr_layer       (wr_layer),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rect_state_led (rect_state_led),
    .busy           (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  lay;
    logic [2:0]  dat;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  obs_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   wr_cnt = 0;
  int   rdy_mode = 0;
  logic stall_prev = 1'b0;
  logic [2:0]  p_lay, p_dat;
  logic [14:0] p_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  always begin
    @(posedge clk_100MHz);
    #2;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = ~wr_ready;
    endcase
  end

  // Every accepted write must be the next one the model predicts; stalled writes must hold.
  always @(negedge clk_100MHz) begin
    wr_t e, a;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 32'({wr_en, wr_layer, wr_addr, wr_data}),
            32'({1'b1, p_lay, p_addr, p_dat}));
      if (wr_en && wr_ready) begin
        a = '{addr: 32'(wr_addr), lay: wr_layer, dat: wr_data};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{addr: 32'hFFFF_FFFF, lay: 3'b000, dat: 3'b000};
        chk("wr_addr", a.addr, e.addr);
        chk("wr_layer", 32'(a.lay), 32'(e.lay));
        chk("wr_data", 32'(a.dat), 32'(e.dat));
        wr_cnt++;
        obs_q.push_back(a);
      end
      stall_prev = wr_en && !wr_ready;
      p_lay  = wr_layer;
      p_addr = wr_addr;
      p_dat  = wr_data;
    end
  end

  function automatic void push_clear();
    for (int i = 0; i < NPIX; i++)
      exp_q.push_back('{addr: 32'(i), lay: 3'b111, dat: 3'b111});
  endfunction

  function automatic int push_rect(input int ax, input int ay, input int bx, input int by,
                                   input logic [2:0] col, input logic ers, input logic [2:0] lay);
    int x0, x1, y0, y1, n;
    bit edge_pix;
    x0 = (ax < bx) ? ax : bx;
    x1 = (ax < bx) ? bx : ax;
    y0 = (ay < by) ? ay : by;
    y1 = (ay < by) ? by : ay;
    n = 0;
    for (int yy = y0; yy <= y1; yy++) begin
      for (int xx = x0; xx <= x1; xx++) begin
        edge_pix = (xx == x0) || (xx == x1) || (yy == y0) || (yy == y1);
`ifdef RECT_FILL_EN
        edge_pix = 1'b1;
`endif
        if (edge_pix && lay != 3'b000) begin
          exp_q.push_back('{addr: 32'(yy * CW + xx), lay: lay, dat: ers ? 3'b111 : col});
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic do_rect(input int ax, input int ay, input int bx, input int by,
                         input logic [2:0] col, input logic ers, input logic [2:0] lay,
                         input bit noise, input bit brush, input int abort_at,
                         input int exp_cycles, input string tag);
    int w0, n, nexp, bad;
    bit got;
    obs_q.delete();
    w0 = wr_cnt;
    cursor_x = 8'(ax);
    cursor_y = 7'(ay);
    tick();
    record_rect_pt = 1'b1;
    tick();
    chk({tag, "_led_pt1"}, 32'(rect_state_led), 32'd1);
    if (noise) begin
      draw_rectangle = 1'b1;
      tick();
      draw_rectangle = 1'b0;
      tick();
      chk({tag, "_led_pt1_hold"}, 32'(rect_state_led), 32'd1);
    end
    cursor_x = 8'(bx);
    cursor_y = 7'(by);
    tick();
    record_rect_pt = 1'b0;
    tick();
    chk({tag, "_led_pt2"}, 32'(rect_state_led), 32'd2);
    color = col;
    eraser = ers;
    layer_en = lay;
    nexp = push_rect(ax, ay, bx, by, col, ers, lay);
    draw_rectangle = 1'b1;
    tick();
    chk({tag, "_led_draw"}, 32'(rect_state_led), 32'd3);
    draw_rectangle = 1'b0;
    color = 3'($urandom);
    eraser = 1'($urandom);
    layer_en = 3'($urandom);
    if (brush) begin
      layer_en = 3'b100;
      brush_x = 8'd159;
      brush_y = 7'd119;
      brush_req = 1'b1;
      exp_q.push_back('{addr: 32'd19199, lay: layer_en, dat: eraser ? 3'b111 : color});
    end
    if (noise) record_rect_pt = 1'b1;
    n = 0;
    bad = 0;
    while (1'b1) begin
      @(negedge clk_100MHz);
      if (!busy || n > 20000) break;
      n++;
      if (brush_ack) bad++;
      if (abort_at > 0 && n == abort_at) begin
        tick();
        reset = 1'b1;
        exp_q.delete();
        return;
      end
    end
    record_rect_pt = 1'b0;
    chk({tag, "_scan_end"}, 32'(busy), 32'd0);
    if (exp_cycles > 0) chk({tag, "_scan_cycles"}, 32'(n), 32'(exp_cycles));
    if (brush) begin
      chk({tag, "_ack_in_draw"}, 32'(bad), 32'd0);
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
        if (brush_ack) got = 1'b1;
        else @(negedge clk_100MHz);
      end
      chk({tag, "_brush_ack"}, 32'(got), 32'd1);
      tick();
      brush_req = 1'b0;
    end
    tick();
    chk({tag, "_led_idle"}, 32'(rect_state_led), 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(nexp + (brush ? 1 : 0)));
    chk({tag, "_model_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_brush(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] lay,
                          input logic [2:0] col, input logic ers);
    int w0, waits;
    bit valid, got;
    w0 = wr_cnt;
    valid = (lay != 3'b000) && (int'(bx) < CW) && (int'(by) < CH);
    brush_x = bx;
    brush_y = by;
    layer_en = lay;
    color = col;
    eraser = ers;
    brush_req = 1'b1;
    if (valid)
      exp_q.push_back('{addr: 32'(int'(by) * CW + int'(bx)), lay: lay, dat: ers ? 3'b111 : col});
    got = 1'b0;
    waits = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_100MHz);
      if (brush_ack) got = 1'b1;
      else waits++;
    end
    tick();
    brush_req = 1'b0;
    chk("brush_ack_seen", 32'(got), 32'd1);
    chk("brush_writes", 32'(wr_cnt - w0), valid ? 32'd1 : 32'd0);
    if (!valid) chk("brush_reject_latency", 32'(waits), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n, ax, ay, bx, by, d, w, h;
    int fill_n;
    bit noise;
`ifdef RECT_FILL_EN
    fill_n = 12;
`else
    fill_n = 10;
`endif

    brush_req = 1'b1;
    brush_x = 8'd3;
    brush_y = 7'd4;
    layer_en = 3'b001;
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_brush_ack", 32'(brush_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_led", 32'(rect_state_led), 32'd0);
    brush_req = 1'b0;
    layer_en = 3'b000;

    push_clear();
    obs_q.delete();
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("clear_busy_first", 32'(busy), 32'd1);
    chk("clear_addr_first", 32'(wr_addr), 32'd0);
    chk("clear_layer_first", 32'(wr_layer), 32'd7);
    n = 0;
    while (1'b1) begin
      @(negedge clk_100MHz);
      if (!busy || n > 25000) break;
      n++;
    end
    chk("clear_busy_cycles", 32'(n), 32'd19200);
    tick();
    chk("clear_writes", 32'(wr_cnt - w0), 32'd19200);
    chk("clear_last_addr", obs_q[obs_q.size() - 1].addr, 32'd19199);
    chk("clear_drained", 32'(exp_q.size()), 32'd0);

    do_rect(10, 5, 13, 7, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 0, 12, "rect_a");
    chk("rect_a_count", 32'(obs_q.size()), 32'(fill_n));
    chk("rect_a_first", obs_q[0].addr, 32'd810);
    chk("rect_a_last", obs_q[obs_q.size() - 1].addr, 32'd1133);
    chk("rect_a_data", 32'(obs_q[0].dat), 32'd1);

    do_rect(13, 7, 10, 5, 3'b001, 1'b1, 3'b001, 1'b1, 1'b0, 0, 12, "rect_erase");
    chk("rect_erase_count", 32'(obs_q.size()), 32'(fill_n));
    chk("rect_erase_first", obs_q[0].addr, 32'd810);
    chk("rect_erase_data", 32'(obs_q[0].dat), 32'd7);

    do_rect(50, 50, 50, 50, 3'b010, 1'b0, 3'b100, 1'b0, 1'b0, 0, 1, "rect_point");
    chk("rect_point_count", 32'(obs_q.size()), 32'd1);
    chk("rect_point_addr", obs_q[0].addr, 32'd8050);

    do_rect(30, 30, 33, 32, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 0, 12, "rect_nolayer");

    do_rect(20, 20, 23, 22, 3'b010, 1'b0, 3'b010, 1'b0, 1'b1, 0, 12, "rect_brush");
    chk("rect_brush_last", obs_q[obs_q.size() - 1].addr, 32'd19199);

    draw_rectangle = 1'b1;
    tick();
    draw_rectangle = 1'b0;
    tick();
    chk("stray_draw_led", 32'(rect_state_led), 32'd0);
    chk("stray_draw_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 24; k++) begin
      rdy_mode = int'($urandom_range(0, 1));
      ax = int'($urandom_range(0, CW - 1));
      ay = int'($urandom_range(0, CH - 1));
      d = int'($urandom_range(0, 12)) - 6;
      bx = ax + d;
      if (bx < 0) bx = 0;
      if (bx > CW - 1) bx = CW - 1;
      d = int'($urandom_range(0, 12)) - 6;
      by = ay + d;
      if (by < 0) by = 0;
      if (by > CH - 1) by = CH - 1;
      if (k % 6 == 0) begin
        bx = ax;
        by = ay;
      end
      w = ((bx > ax) ? bx - ax : ax - bx) + 1;
      h = ((by > ay) ? by - ay : ay - by) + 1;
      noise = (k % 3 == 0);
      do_rect(ax, ay, bx, by, 3'($urandom), 1'($urandom), 3'($urandom), noise, 1'b0, 0,
              (rdy_mode == 0) ? w * h : 0, "rand_rect");
      if (k % 2 == 0)
        do_brush(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 3'($urandom),
                 3'($urandom), 1'($urandom));
      else
        do_brush(8'($urandom_range(0, CW - 1)), 7'($urandom_range(0, CH - 1)),
                 3'($urandom_range(1, 7)), 3'($urandom), 1'($urandom));
    end

    rdy_mode = 0;
    do_rect(10, 5, 13, 7, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 5, 0, "rect_abort");
    w0 = wr_cnt;
    tick();
    push_clear();
    rdy_mode = 2;
    reset = 1'b0;
    #1;
    chk("reclear_busy", 32'(busy), 32'd1);
    chk("reclear_addr0", 32'(wr_addr), 32'd0);
    n = 0;
    while (1'b1) begin
      @(negedge clk_100MHz);
      if (!busy || n > 60000) break;
      n++;
    end
    chk("reclear_done", 32'(busy), 32'd0);
    tick();
    chk("reclear_writes", 32'(wr_cnt - w0), 32'd19200);
    chk("reclear_drained", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
